mem_arbiter: RTL and testbench

- Shares the core's single memory request port between instruction-cache refill and data-cache refill/writeback.
- Sits between the I-cache (the source of the fetch stage's cache_stall) and the D-cache on one side, and the memory/host interface on the other.
- Grants one requester at a time, latches its command, drives the memory handshake, and returns the response with a one-cycle done pulse.
- Uses round-robin priority on ties so that fetch cannot starve data traffic, and data traffic cannot starve fetch.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory-port arbiter.
package mem_arb_pkg;

   localparam int DEFAULT_ADDR_W = 36;
   localparam int DEFAULT_LINE_W = 512;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to whoever was not granted last.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic req_ic,
   input  logic req_dc,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = req_ic | req_dc;
      grant_id    = REQ_IC;
      if (req_ic && req_dc) begin
         grant_id = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
      end else if (req_dc) begin
         grant_id = REQ_DC;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request port between I-cache refill and D-cache refill/writeback,
// one latched command at a time, with a one-cycle done pulse back to the owner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int LINE_W = DEFAULT_LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_done,
   output logic [LINE_W-1:0] ic_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_done,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              mem_req_valid,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [LINE_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [LINE_W-1:0] mem_resp_data,
   output logic              busy
);

   // Memory handshake: a command transfers on a cycle where mem_req_valid and
   // mem_req_ready are both high; valid and the command stay put until then.
   // mem_resp_valid is only honoured in WAIT, one response per command.

   state_t  state;
   req_id_t owner;
   req_id_t last_grant;
   logic    grant_valid;
   logic    grant_id;

   rr_arb2 u_rr_arb2 (
      .req_ic      (ic_req),
      .req_dc      (dc_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= REQ_IC;
         last_grant    <= REQ_IC;
         busy          <= 1'b0;
         ic_done       <= 1'b0;
         dc_done       <= 1'b0;
         ic_rdata      <= '0;
         dc_rdata      <= '0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
      end else begin
         // done is a pulse: it is only ever set on the edge into DONE
         ic_done <= 1'b0;
         dc_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner      <= req_id_t'(grant_id);
                  last_grant <= req_id_t'(grant_id);
                  if (grant_id == REQ_DC) begin
                     mem_req_we    <= dc_we;
                     mem_req_addr  <= dc_addr;
                     mem_req_wdata <= dc_wdata;
                  end else begin
                     mem_req_we    <= 1'b0;
                     mem_req_addr  <= ic_addr;
                     mem_req_wdata <= '0;
                  end
                  mem_req_valid <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  if (owner == REQ_IC) begin
                     ic_rdata <= mem_resp_data;
                     ic_done  <= 1'b1;
                  end else begin
                     // a writeback ack carries no data; keep the last refill line
                     if (!mem_req_we) begin
                        dc_rdata <= mem_resp_data;
                     end
                     dc_done <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy          <= 1'b0;
               mem_req_valid <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal timing checks.
module tb_mem_arbiter;

   localparam int ADDR_W = 36;
   localparam int LINE_W = 512;

   logic              clk = 1'b0;
   logic              rst;
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic              ic_done;
   logic [LINE_W-1:0] ic_rdata;
   logic              dc_req;
   logic              dc_we;
   logic [ADDR_W-1:0] dc_addr;
   logic [LINE_W-1:0] dc_wdata;
   logic              dc_done;
   logic [LINE_W-1:0] dc_rdata;
   logic              mem_req_valid;
   logic              mem_req_we;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [LINE_W-1:0] mem_req_wdata;
   logic              mem_req_ready;
   logic              mem_resp_valid;
   logic [LINE_W-1:0] mem_resp_data;
   logic              busy;

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .ic_req         (ic_req),
      .ic_addr        (ic_addr),
      .ic_done        (ic_done),
      .ic_rdata       (ic_rdata),
      .dc_req         (dc_req),
      .dc_we          (dc_we),
      .dc_addr        (dc_addr),
      .dc_wdata       (dc_wdata),
      .dc_done        (dc_done),
      .dc_rdata       (dc_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .busy           (busy)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      if (a == 36'h040) return {64{8'hA5}};
      return {16{a[31:0] ^ 32'h5A5A_0000}};
   endfunction

   // ---------------- memory responder ----------------
   int ready_lat = 0;
   int resp_lat  = 0;
   int stray_a   = -1;
   int stray_b   = -1;

   initial begin
      int mp = 0;
      int cnt = 0;
      logic [ADDR_W-1:0] m_addr = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         mem_resp_data  = {16{$urandom}};
         case (mp)
            0: if (mem_req_valid) begin
               if (cnt >= ready_lat) begin
                  mem_req_ready = 1'b1;
                  m_addr = mem_req_addr;
                  mp = 1;
                  cnt = 0;
               end else begin
                  cnt++;
               end
            end
            default: begin
               if (cnt >= resp_lat) begin
                  mem_resp_valid = 1'b1;
                  mem_resp_data  = line_of(m_addr);
                  mp = 0;
                  cnt = 0;
               end else begin
                  cnt++;
               end
            end
         endcase
         if (cyc == stray_a || cyc == stray_b) mem_resp_valid = 1'b1;
      end
   end

   // ---------------- transaction model + per-cycle compare ----------------
   bit                m_active, m_accepted, m_answered, m_dc, m_we, m_last_dc;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wdata, m_ic_rdata, m_dc_rdata;

   int                valid_cycles = 0;
   logic [ADDR_W-1:0] seen_addr;
   logic [LINE_W-1:0] seen_wdata;
   logic              seen_we;
   int                ic_done_cnt = 0;
   int                dc_done_cnt = 0;
   logic [0:0]        done_log[$];
   logic [0:0]        exp_q[$];

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_active = 0; m_accepted = 0; m_answered = 0; m_last_dc = 0;
            m_ic_rdata = '0; m_dc_rdata = '0;
            chk("rst_busy", busy, '0);
            chk("rst_valid", mem_req_valid, '0);
            chk("rst_we", mem_req_we, '0);
            chk("rst_addr", mem_req_addr, '0);
            chk("rst_wdata", mem_req_wdata, '0);
            chk("rst_ic_done", ic_done, '0);
            chk("rst_dc_done", dc_done, '0);
            chk("rst_ic_rdata", ic_rdata, '0);
            chk("rst_dc_rdata", dc_rdata, '0);
         end else begin
            chk("busy", busy, m_active);
            chk("req_valid", mem_req_valid, m_active && !m_accepted);
            chk("ic_done", ic_done, m_active && m_answered && !m_dc);
            chk("dc_done", dc_done, m_active && m_answered && m_dc);
            chk("ic_rdata", ic_rdata, m_ic_rdata);
            chk("dc_rdata", dc_rdata, m_dc_rdata);
            if (m_active && !m_accepted) begin
               chk("req_we", mem_req_we, m_we);
               chk("req_addr", mem_req_addr, m_addr);
               chk("req_wdata", mem_req_wdata, m_wdata);
            end
            if (mem_req_valid) begin
               valid_cycles++;
               seen_addr = mem_req_addr; seen_wdata = mem_req_wdata; seen_we = mem_req_we;
            end
            if (ic_done) begin ic_done_cnt++; done_log.push_back(1'b0); end
            if (dc_done) begin dc_done_cnt++; done_log.push_back(1'b1); end
            // advance the model on the inputs the DUT sees at the coming edge
            if (!m_active) begin
               if (ic_req || dc_req) begin
                  m_dc = (ic_req && dc_req) ? !m_last_dc : dc_req;
                  m_last_dc = m_dc;
                  m_active = 1; m_accepted = 0; m_answered = 0;
                  m_we    = m_dc ? dc_we : 1'b0;
                  m_addr  = m_dc ? dc_addr : ic_addr;
                  m_wdata = m_dc ? dc_wdata : '0;
               end
            end else if (!m_accepted) begin
               m_accepted = mem_req_ready;
            end else if (!m_answered) begin
               if (mem_resp_valid) begin
                  m_answered = 1;
                  if (!m_dc) m_ic_rdata = mem_resp_data;
                  else if (!m_we) m_dc_rdata = mem_resp_data;
               end
            end else begin
               m_active = 0;
            end
         end
      end
   end

   // ---------------- requester driver tasks ----------------
   task automatic do_ic(input logic [ADDR_W-1:0] addr, output int done_at,
                        output logic [LINE_W-1:0] rdata);
      bit seen = 0;
      done_at = -1;
      rdata = '0;
      ic_addr = addr;
      ic_req = 1'b1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (ic_done) begin
            seen = 1; done_at = cyc; rdata = ic_rdata;
         end
         @(posedge clk);
         #1;
      end
      ic_req = 1'b0;
      chk("ic_done_seen", seen, 1'b1);
   endtask

   task automatic do_dc(input logic we, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                        input bit scramble, output int done_at, output logic [LINE_W-1:0] rdata);
      bit seen = 0;
      done_at = -1;
      rdata = '0;
      dc_we = we; dc_addr = addr; dc_wdata = wdata;
      dc_req = 1'b1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (dc_done) begin
            seen = 1; done_at = cyc; rdata = dc_rdata;
         end
         @(posedge clk);
         #1;
         if (scramble && i == 1) begin
            dc_addr = ~addr; dc_wdata = ~wdata; dc_we = ~we;
         end
      end
      dc_req = 1'b0;
      chk("dc_done_seen", seen, 1'b1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int t0, d_ic, d_dc, ic_cnt0, dc_cnt0;
      logic [LINE_W-1:0] r_ic, r_dc, wpat;
      rst = 1'b1;
      ic_req = 0; ic_addr = '0;
      dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single IC read, ready immediate, response two cycles into WAIT
      ready_lat = 0; resp_lat = 2;
      valid_cycles = 0; dc_cnt0 = dc_done_cnt;
      t0 = cyc;
      do_ic(36'h040, d_ic, r_ic);
      chk("t1_done_cycle", 32'(d_ic - t0), 32'd5);
      chk("t1_rdata", r_ic, {64{8'hA5}});
      chk("t1_addr", seen_addr, 36'h040);
      chk("t1_we", seen_we, 1'b0);
      chk("t1_valid_cycles", 32'(valid_cycles), 32'd1);
      chk("t1_no_dc_done", 32'(dc_done_cnt - dc_cnt0), 32'd0);

      // DC refill read to load dc_rdata, then writeback with ready stalled 3 cycles
      ready_lat = 0; resp_lat = 0;
      t0 = cyc;
      do_dc(1'b0, 36'h200, '0, 1'b0, d_dc, r_dc);
      chk("t2a_done_cycle", 32'(d_dc - t0), 32'd3);
      chk("t2a_rdata", r_dc, line_of(36'h200));
      ready_lat = 3; resp_lat = 1;
      valid_cycles = 0;
      wpat = {32{16'h1234}};
      t0 = cyc;
      do_dc(1'b1, 36'h100, wpat, 1'b1, d_dc, r_dc);
      chk("t2_valid_cycles", 32'(valid_cycles), 32'd4);
      chk("t2_addr", seen_addr, 36'h100);
      chk("t2_wdata", seen_wdata, wpat);
      chk("t2_we", seen_we, 1'b1);
      chk("t2_done_cycle", 32'(d_dc - t0), 32'd7);
      chk("t2_rdata_kept", r_dc, line_of(36'h200));

      // both requesters continuously busy from reset: DC, IC, DC, IC
      pulse_reset();
      ready_lat = 0; resp_lat = 0;
      done_log.delete();
      exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
      fork
         begin
            for (int k = 0; k < 2; k++) do_ic(36'h080 + 36'(k * 64), d_ic, r_ic);
         end
         begin
            for (int k = 0; k < 2; k++) do_dc(1'b0, 36'h300 + 36'(k * 64), '0, 1'b0, d_dc, r_dc);
         end
      join
      chk("t3_done_count", 32'(done_log.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t3_order_%0d", k),
             (k < done_log.size()) ? done_log[k] : 1'bx, exp_q[k]);
      end

      // stray responses in IDLE and ISSUE cause nothing
      ready_lat = 2; resp_lat = 1;
      ic_cnt0 = ic_done_cnt; dc_cnt0 = dc_done_cnt;
      stray_a = cyc + 1;
      repeat (3) @(posedge clk);
      #1;
      t0 = cyc;
      stray_b = t0 + 2;
      do_ic(36'h700, d_ic, r_ic);
      stray_a = -1; stray_b = -1;
      chk("t4_done_cycle", 32'(d_ic - t0), 32'd6);
      chk("t4_ic_done_once", 32'(ic_done_cnt - ic_cnt0), 32'd1);
      chk("t4_no_dc_done", 32'(dc_done_cnt - dc_cnt0), 32'd0);
      chk("t4_rdata", r_ic, line_of(36'h700));

      // reset during WAIT with dc_req held; the stale response lands in ISSUE
      ready_lat = 0; resp_lat = 4;
      dc_cnt0 = dc_done_cnt;
      t0 = cyc;
      fork
         do_dc(1'b0, 36'h400, '0, 1'b0, d_dc, r_dc);
         begin
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
         end
      join
      chk("t5_done_cycle", 32'(d_dc - t0), 32'd13);
      chk("t5_dc_done_once", 32'(dc_done_cnt - dc_cnt0), 32'd1);
      chk("t5_rdata", r_dc, line_of(36'h400));

      // IC request arrives while a DC read waits for its response
      ready_lat = 0; resp_lat = 2;
      t0 = cyc;
      fork
         do_dc(1'b0, 36'h500, '0, 1'b0, d_dc, r_dc);
         begin
            repeat (3) @(posedge clk);
            #1;
            do_ic(36'h600, d_ic, r_ic);
         end
      join
      chk("t6_dc_done_cycle", 32'(d_dc - t0), 32'd5);
      chk("t6_ic_done_cycle", 32'(d_ic - t0), 32'd11);
      chk("t6_ic_rdata", r_ic, line_of(36'h600));
      chk("t6_dc_rdata", r_dc, line_of(36'h500));

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
